dff_and_mux: RTL and testbench

DFF_AND_MUX -- requirements
Module: dff_and_mux

---
 rtl/dff_and_mux.sv | 60 ++++++
 tb/tb_dff_and_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dff_and_mux.sv
// Three-stage delay chain on d with a tap mux selecting d, s1, s2 or s3 onto q.
// Define DFF_AND_MUX_OUT_REG_EN to register the mux output (adds one cycle to every tap).
module dff_and_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] s1_d, s2_d, s3_d;
    logic [WIDTH-1:0] tap;

    // Chain shifts unconditionally; sel never touches the stored taps.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    always_comb begin
        tap = d;
        case (sel)
            2'b00:   tap = d;
            2'b01:   tap = s1_q;
            2'b10:   tap = s2_q;
            2'b11:   tap = s3_q;
            default: tap = d;
        endcase
    end

`ifdef DFF_AND_MUX_OUT_REG_EN
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= tap;
    end

    assign q = out_q;
`else
    assign q = tap;
`endif

endmodule

// File: tb/tb_dff_and_mux.sv
// Bench for dff_and_mux: history-array reference model checked on every negedge and on
// stimulus-raised events between edges, plus hand-computed literal expectations.
module tb_dff_and_mux;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d;
    logic [1:0]   sel;
    logic [W-1:0] q;

    int n_cmp  = 0;
    int n_fail = 0;

    // hist[k] is the d value sampled k+1 rising edges ago (zero after reset)
    logic [W-1:0] hist [3] = '{8'h00, 8'h00, 8'h00};
    logic [W-1:0] oreg = '0;
    event chk_ev;

    dff_and_mux #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .q(q));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] tap_ref();
        if (sel == 2'b00) return d;
        return hist[int'(sel) - 1];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '{8'h00, 8'h00, 8'h00};
            oreg <= '0;
        end else begin
            oreg <= tap_ref();
            hist <= '{d, hist[0], hist[1]};
        end
    end

    always begin
        @(negedge clk or chk_ev);
`ifdef DFF_AND_MUX_OUT_REG_EN
        check("model", q, oreg);
`else
        check("model", q, tap_ref());
`endif
    end

    task automatic setchk(input logic [1:0] s, input logic [W-1:0] exp, input string name);
        sel = s;
        #1;
        check(name, q, exp);
        ->chk_ev;
    endtask

    initial begin
        rst_n = 1'b0;
        d     = '0;
        sel   = 2'b01;
        #1;
`ifndef DFF_AND_MUX_OUT_REG_EN
        // reset state, no clock edge yet
        setchk(2'b01, 8'h00, "rst_sel01");
        setchk(2'b10, 8'h00, "rst_sel10");
        setchk(2'b11, 8'h00, "rst_sel11");
        d = 8'hA5;
        setchk(2'b00, 8'hA5, "rst_sel00_d");

        // successive d values, tap 3 and tap 1
        @(posedge clk); #2 d = 8'h01;
        #1 rst_n = 1'b1;
        @(posedge clk); #2 d = 8'h02;
        @(posedge clk); #2 d = 8'h03;
        @(posedge clk); #1 d = 8'h04;
        setchk(2'b11, 8'h01, "seq_e3_sel11");
        @(posedge clk); #1;
        check("seq_e4_sel11", q, 8'h02);
        setchk(2'b01, 8'h04, "seq_e4_sel01");

        // load 30,20,10 then step sel between edges
        d = 8'h30;
        @(posedge clk); #1 d = 8'h20;
        @(posedge clk); #1 d = 8'h10;
        @(posedge clk); #1 d = 8'h77;
        #1;
        setchk(2'b00, 8'h77, "step_sel00"); #1;
        setchk(2'b01, 8'h10, "step_sel01"); #1;
        setchk(2'b10, 8'h20, "step_sel10"); #1;
        setchk(2'b11, 8'h30, "step_sel11");

        // fill with FF, then async reset between edges
        @(posedge clk); #1 d = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("fill_ff", q, 8'hFF);
        rst_n = 1'b0;
        setchk(2'b01, 8'h00, "midrst_sel01");
        setchk(2'b10, 8'h00, "midrst_sel10");
        setchk(2'b11, 8'h00, "midrst_sel11");
        #1;
        setchk(2'b00, 8'hFF, "midrst_sel00");
        d = 8'h3C;
        #1;
        check("midrst_sel00_dchg", q, 8'h3C);
        rst_n = 1'b1;
        d = 8'hC3;
        @(posedge clk); #1;
        setchk(2'b01, 8'hC3, "post_rst_s1");
        setchk(2'b10, 8'h00, "post_rst_s2");
        setchk(2'b11, 8'h00, "post_rst_s3");
`else
        check("rst_out_reg", q, 8'h00);
        @(posedge clk); #2 rst_n = 1'b1;
        sel = 2'b00;
        d   = 8'h5A;
        #1;
        check("oreg_sel00_before_edge", q, 8'h00);
        @(posedge clk); #1;
        check("oreg_sel00_after_edge", q, 8'h5A);
        sel = 2'b11;
        d   = 8'h11;
        @(posedge clk); #1 d = 8'h22;
        @(posedge clk); #1 d = 8'h33;
        @(posedge clk); #1 d = 8'h44;
        @(posedge clk); #1;
        check("oreg_sel11_e4", q, 8'h11);
        @(posedge clk); #1;
        check("oreg_sel11_e5", q, 8'h22);
`endif

        // sweep d 0..255, sel rotates every quarter period
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1 d = W'(i);
            for (int k = 0; k < 4; k++) begin
                sel = 2'((i + k) % 4);
                #1;
                ->chk_ev;
                if (k == 1) #2;
                else if (k < 3) #1;
            end
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
